seg_scan_n: RTL and testbench

Parametrised time-multiplexed driver for a common-anode seven-segment display bank of `DIGITS` digits with decimal points. It is the general-purpose display back end for board-level designs that show hex register or bus values. It adds the following over a fixed 4-digit scanner:
- per-digit enable mask
- leading-zero blanking
- PWM brightness control
- frame-coherent input capture
- a frame-start strobe

---
 rtl/seg_scan_n.sv | 155 +++++++++++++++
 tb/tb_seg_scan_n.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_n.sv
// Time-multiplexed common-anode seven-segment scanner with per-digit enable,
// leading-zero blanking, PWM brightness and frame-coherent input capture.
module seg_scan_n #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DIV_BITS    = 16,
  parameter int unsigned BRIGHT_BITS = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [4*DIGITS-1:0]      x,
  input  logic [DIGITS-1:0]        dp_in,
  input  logic [DIGITS-1:0]        aen,
  input  logic                     blank_lz,
  input  logic [BRIGHT_BITS-1:0]   bright,
  output logic [6:0]               a_to_g,
  output logic                     dp,
  output logic [DIGITS-1:0]        an,
  output logic                     frame
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [4*DIGITS-1:0] x_q;
  logic [DIGITS-1:0]   dp_in_q;
  logic [DIGITS-1:0]   aen_q;
  logic                blank_lz_q;

  logic [6:0]          a_to_g_d;
  logic                dp_d;
  logic [DIGITS-1:0]   an_d;
  logic                frame_d;

  logic                wrap;
  logic                last;
  logic                load;

  logic [DIGITS-1:0]   zero_from;
  logic                zero_acc;
  logic [3:0]          nib_sel;
  logic                aen_sel;
  logic                dp_sel;
  logic                zero_sel;
  logic                blanked;
  logic                pwm_on;
  logic                lit;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  assign wrap = &cnt_q;
  assign last = (idx_q == IdxW'(DIGITS - 1));
  assign load = wrap && last;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  // zero_from[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc & (x_q[4*i +: 4] == 4'h0);
      zero_from[i] = zero_acc;
    end
  end

  always_comb begin
    nib_sel  = 4'h0;
    aen_sel  = 1'b0;
    dp_sel   = 1'b0;
    zero_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_sel  = x_q[4*i +: 4];
        aen_sel  = aen_q[i];
        dp_sel   = dp_in_q[i];
        zero_sel = zero_from[i];
      end
    end
  end

  assign blanked = blank_lz_q && (idx_q != '0) && zero_sel;
  assign pwm_on  = (cnt_q[DIV_BITS-1 -: BRIGHT_BITS] < bright);
  assign lit     = aen_sel && !blanked && pwm_on;

  always_comb begin
    an_d     = '1;
    a_to_g_d = 7'h7F;
    dp_d     = 1'b1;
    if (lit) begin
      an_d     = ~(DIGITS'(1) << idx_q);
      a_to_g_d = seg_enc(nib_sel);
      dp_d     = ~dp_sel;
    end
    frame_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      x_q        <= x;
      dp_in_q    <= dp_in;
      aen_q      <= aen;
      blank_lz_q <= blank_lz;
      an         <= '1;
      a_to_g     <= 7'h7F;
      dp         <= 1'b1;
      frame      <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      // Shadows only change at a frame boundary so a frame never mixes old and new data.
      if (load) begin
        x_q        <= x;
        dp_in_q    <= dp_in;
        aen_q      <= aen;
        blank_lz_q <= blank_lz;
      end
      an     <= an_d;
      a_to_g <= a_to_g_d;
      dp     <= dp_d;
      frame  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// Scoreboard bench for seg_scan_n: stimulus queues expected lit bursts, a monitor
// reassembles bursts from the outputs and compares them in order.
module tb_seg_scan_n;

  localparam int unsigned D  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned BB = 2;

  logic            clk;
  logic            clr;
  logic [4*D-1:0]  x;
  logic [D-1:0]    dp_in;
  logic [D-1:0]    aen;
  logic            blank_lz;
  logic [BB-1:0]   bright;
  logic [6:0]      a_to_g;
  logic            dp;
  logic [D-1:0]    an;
  logic            frame;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] len;
  } burst_t;

  burst_t sb[$];
  burst_t cur;
  logic   in_burst;
  logic   mon_en;
  int     tests;
  int     fails;

  seg_scan_n #(
    .DIGITS     (D),
    .DIV_BITS   (DB),
    .BRIGHT_BITS(BB)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .x       (x),
    .dp_in   (dp_in),
    .aen     (aen),
    .blank_lz(blank_lz),
    .bright  (bright),
    .a_to_g  (a_to_g),
    .dp      (dp),
    .an      (an),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input logic [7:0] l);
    burst_t b;
    b.an  = a;
    b.seg = s;
    b.dp  = d;
    b.len = l;
    sb.push_back(b);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    push(4'b1110, s0, 1'b1, 8'd12);
    push(4'b1101, s1, 1'b1, 8'd12);
    push(4'b1011, s2, 1'b1, 8'd12);
    push(4'b0111, s3, 1'b1, 8'd12);
  endtask

  task automatic close_burst();
    burst_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL burst_unexpected: got an=%b seg=%h dp=%b len=%0d expected none",
               cur.an, cur.seg, cur.dp, cur.len);
    end else begin
      e = sb.pop_front();
      if (cur !== e) begin
        fails++;
        $display("FAIL burst: got an=%b seg=%h dp=%b len=%0d expected an=%b seg=%h dp=%b len=%0d",
                 cur.an, cur.seg, cur.dp, cur.len, e.an, e.seg, e.dp, e.len);
      end
    end
    in_burst = 1'b0;
  endtask

  // Monitor: one burst = consecutive cycles with the same lit digit and pattern.
  always @(negedge clk) begin
    if (mon_en) begin
      if ($countones(~an) > 1) begin
        tests++;
        fails++;
        $display("FAIL anode_onehot: got an=%b expected at most one low bit", an);
      end
      if (an == 4'hF) begin
        if (a_to_g !== 7'h7F || dp !== 1'b1) begin
          tests++;
          fails++;
          $display("FAIL dark_segments: got seg=%h dp=%b expected seg=7f dp=1", a_to_g, dp);
        end
        if (in_burst) close_burst();
      end else if (in_burst && cur.an == an && cur.seg == a_to_g && cur.dp == dp) begin
        cur.len = cur.len + 8'd1;
      end else begin
        if (in_burst) close_burst();
        cur.an   = an;
        cur.seg  = a_to_g;
        cur.dp   = dp;
        cur.len  = 8'd1;
        in_burst = 1'b1;
      end
    end
  end

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_frames(input int n);
    repeat (64 * n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int per;
    logic found;
    tests    = 0;
    fails    = 0;
    mon_en   = 1'b0;
    in_burst = 1'b0;
    cur      = '0;

    // Reset held three cycles
    clr      = 1'b1;
    x        = 16'hFFFF;
    dp_in    = 4'h0;
    aen      = 4'hF;
    blank_lz = 1'b0;
    bright   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      mon_en = 1'b1;
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_seg", 32'(a_to_g), 32'h7F);
      chk("reset_dp", 32'(dp), 32'h1);
      chk("reset_frame", 32'(frame), 32'h0);
    end
    clr = 1'b0;
    push_frame(7'h38, 7'h38, 7'h38, 7'h38);
    @(posedge clk);
    @(negedge clk);
    chk("frame_after_release", 32'(frame), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("frame_one_cycle", 32'(frame), 32'h0);
    repeat (62) @(posedge clk);
    @(negedge clk);

    // Scan order and frame period
    x = 16'h1234;
    pulse_clr();
    push_frame(7'h4C, 7'h06, 7'h12, 7'h4F);
    push_frame(7'h4C, 7'h06, 7'h12, 7'h4F);
    @(posedge clk);
    @(negedge clk);
    chk("scan_frame_start", 32'(frame), 32'h1);
    per   = 0;
    found = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!found) begin
        @(posedge clk);
        @(negedge clk);
        if (frame) begin
          found = 1'b1;
          per   = k;
        end
      end
    end
    chk("frame_period", 32'(per), 32'd64);
    repeat (63) @(posedge clk);
    @(negedge clk);

    // Leading-zero blanking
    x        = 16'h0050;
    blank_lz = 1'b1;
    pulse_clr();
    push(4'b1110, 7'h01, 1'b1, 8'd12);
    push(4'b1101, 7'h24, 1'b1, 8'd12);
    run_frames(1);

    x = 16'h0000;
    pulse_clr();
    push(4'b1110, 7'h01, 1'b1, 8'd12);
    run_frames(1);

    x        = 16'h0050;
    blank_lz = 1'b0;
    pulse_clr();
    push_frame(7'h01, 7'h24, 7'h01, 7'h01);
    run_frames(1);

    // Enable mask, decimal point and PWM duty
    x     = 16'h1234;
    aen   = 4'b1010;
    dp_in = 4'b0010;
    pulse_clr();
    push(4'b1101, 7'h06, 1'b0, 8'd12);
    push(4'b0111, 7'h4F, 1'b1, 8'd12);
    run_frames(1);

    bright = 2'd1;
    pulse_clr();
    push(4'b1101, 7'h06, 1'b0, 8'd4);
    push(4'b0111, 7'h4F, 1'b1, 8'd4);
    run_frames(1);

    bright = 2'd0;
    pulse_clr();
    run_frames(1);

    // Shadow coherence: change x while idx=1
    bright = 2'd3;
    aen    = 4'hF;
    dp_in  = 4'h0;
    x      = 16'h1234;
    pulse_clr();
    push_frame(7'h4C, 7'h06, 7'h12, 7'h4F);
    push_frame(7'h42, 7'h31, 7'h60, 7'h08);
    repeat (20) @(posedge clk);
    #1 x = 16'hABCD;
    repeat (108) @(posedge clk);
    @(negedge clk);

    // Mid-scan reset while idx=2
    x = 16'h1234;
    pulse_clr();
    push(4'b1110, 7'h4C, 1'b1, 8'd12);
    push(4'b1101, 7'h06, 1'b1, 8'd12);
    push(4'b1011, 7'h12, 1'b1, 8'd5);
    push_frame(7'h4C, 7'h06, 7'h12, 7'h4F);
    repeat (37) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_an_dark", 32'(an), 32'hF);
    chk("midreset_frame", 32'(frame), 32'h0);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_frame_pulse", 32'(frame), 32'h1);
    repeat (63) @(posedge clk);
    @(negedge clk);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
